// File: rtl/fpu_req_arbiter_pkg.sv
// Shared types for the FP32 adder/subtracter request arbiter.
// Holds the FSM encoding and the operand bundle driven onto the datapath.
package fpu_arb_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            sub;
    } fpu_op_t;

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Bus between client engines, the arbiter and the shared FP32 datapath.
// Both channels use valid/ready: a transfer happens on any clock edge where valid and ready are both 1; valid never waits on ready.
interface fpu_req_arbiter_if #(
    parameter int NREQ = 2
);
    import fpu_arb_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*FP_W-1:0] req_a;
    logic [NREQ*FP_W-1:0] req_b;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [FP_W-1:0]      rsp_data;
    logic                 rsp_zflag;
    logic [FP_W-1:0]      fpu_a;
    logic [FP_W-1:0]      fpu_b;
    logic                 fpu_sub;
    logic [FP_W-1:0]      fpu_out;
    logic                 fpu_zflag;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready, fpu_out, fpu_zflag,
        input  req_ready, rsp_valid, rsp_data, rsp_zflag, fpu_a, fpu_b, fpu_sub
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready, fpu_out, fpu_zflag,
        output req_ready, rsp_valid, rsp_data, rsp_zflag, fpu_a, fpu_b, fpu_sub
    );

endinterface

// File: rtl/fpu_req_arbiter_rr_grant.sv
// Combinational round-robin select: first asserted request at or above i_ptr, wrapping modulo NREQ.
// Reusable by any shared-resource arbiter that keeps its own pointer register.
module rr_grant #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [IDW-1:0]  o_gnt_idx,
    output logic            o_gnt_any
);

    logic [IDW:0] w_sum;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (i_req[w_sum[IDW-1:0]]) begin
                o_gnt_idx = w_sum[IDW-1:0];
                o_gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 add/sub datapath among NREQ clients.
// One operation in flight: grant in IDLE, hold operands FPU_LAT cycles in EXEC, return the result in RESP.
module fpu_req_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int FPU_LAT = 1,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_req_arbiter_if.slave     bus,
    output arb_state_t           o_state,
    output logic [IDW-1:0]       o_owner
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(FPU_LAT - 1);

    arb_state_t        r_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_owner;
    logic [CNT_W-1:0]  r_lat_cnt;
    fpu_op_t           r_op;
    logic [FP_W-1:0]   r_rsp_data;
    logic              r_rsp_zflag;

    arb_state_t        w_state_nxt;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [IDW-1:0]    w_owner_nxt;
    logic [CNT_W-1:0]  w_lat_cnt_nxt;
    fpu_op_t           w_op_nxt;
    logic [FP_W-1:0]   w_rsp_data_nxt;
    logic              w_rsp_zflag_nxt;
    logic [NREQ-1:0]   w_req_ready;
    logic [NREQ-1:0]   w_rsp_valid;

    logic [IDW-1:0]    w_gnt_idx;
    logic              w_gnt_any;
    fpu_op_t           w_req_op;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    always_comb begin
        w_req_op.a   = bus.req_a[int'(w_gnt_idx)*FP_W +: FP_W];
        w_req_op.b   = bus.req_b[int'(w_gnt_idx)*FP_W +: FP_W];
        w_req_op.sub = bus.req_sub[w_gnt_idx];
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_op_nxt        = r_op;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_zflag_nxt = r_rsp_zflag;
        w_req_ready     = '0;
        w_rsp_valid     = '0;

        case (r_state)
            IDLE: begin
                // A grant is always accepted, so grant and handshake coincide.
                if (w_gnt_any) begin
                    w_req_ready[w_gnt_idx] = 1'b1;
                    w_op_nxt               = w_req_op;
                    w_owner_nxt            = w_gnt_idx;
                    w_ptr_nxt              = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                    w_lat_cnt_nxt          = LAT_INIT;
                    w_state_nxt            = EXEC;
                end
            end
            EXEC: begin
                if (r_lat_cnt != '0) begin
                    w_lat_cnt_nxt = r_lat_cnt - 1'b1;
                end else begin
                    w_rsp_data_nxt  = bus.fpu_out;
                    w_rsp_zflag_nxt = bus.fpu_zflag;
                    w_state_nxt     = RESP;
                end
            end
            RESP: begin
                w_rsp_valid[r_owner] = 1'b1;
                if (bus.rsp_ready[r_owner]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_lat_cnt   <= '0;
            r_op        <= '0;
            r_rsp_data  <= '0;
            r_rsp_zflag <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_op        <= w_op_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_zflag <= w_rsp_zflag_nxt;
        end
    end

    // Handshake strobes are masked during reset so no transfer can slip through an aborting cycle.
    assign bus.req_ready = rst ? '0 : w_req_ready;
    assign bus.rsp_valid = rst ? '0 : w_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zflag = r_rsp_zflag;
    assign bus.fpu_a     = r_op.a;
    assign bus.fpu_b     = r_op.b;
    assign bus.fpu_sub   = r_op.sub;

    assign o_state = r_state;
    assign o_owner = r_owner;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Bench for fpu_req_arbiter: two instances (NREQ=2/FPU_LAT=1 and NREQ=3/FPU_LAT=3) with an FP32 datapath stub.
// A transaction-level model is compared every cycle; directed sequences pin grants, latencies and results.
module tb_fpu_req_arbiter;
    import fpu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int nreq [2] = '{2, 3};
    int lat  [2] = '{1, 3};

    // stimulus (index 0 = small instance, 1 = three-requester instance)
    logic [2:0]  v_valid  [2];
    logic [2:0]  v_sub    [2];
    logic [2:0]  v_rready [2];
    logic [31:0] v_a      [2][3];
    logic [31:0] v_b      [2][3];

    // observed outputs
    logic [2:0]  o_ready  [2];
    logic [2:0]  o_rvalid [2];
    logic [31:0] o_rdata  [2];
    logic        o_rz     [2];
    logic [31:0] o_fa     [2];
    logic [31:0] o_fb     [2];
    logic        o_fs     [2];
    arb_state_t  o_st     [2];
    logic [1:0]  o_own    [2];

    arb_state_t st0, st1;
    logic       own0;
    logic [1:0] own1;

    // FP32 datapath stub via double precision (exact for the normal values used here)
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        if (x[30:0] == 31'd0) d = {x[31], 63'd0};
        else begin
            e = {3'b000, x[30:23]} + 11'd896;
            d = {x[31], e, x[22:0], 29'd0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b, input logic s);
        return s ? r2f(f2r(a) - f2r(b)) : r2f(f2r(a) + f2r(b));
    endfunction

    fpu_req_arbiter_if #(.NREQ(2)) bus0 ();
    fpu_req_arbiter_if #(.NREQ(3)) bus1 ();

    assign bus0.req_valid = v_valid[0][1:0];
    assign bus0.req_sub   = v_sub[0][1:0];
    assign bus0.rsp_ready = v_rready[0][1:0];
    assign bus0.req_a     = {v_a[0][1], v_a[0][0]};
    assign bus0.req_b     = {v_b[0][1], v_b[0][0]};
    assign bus0.fpu_out   = fp_addsub(bus0.fpu_a, bus0.fpu_b, bus0.fpu_sub);
    assign bus0.fpu_zflag = (bus0.fpu_out[30:0] == 31'd0);

    assign bus1.req_valid = v_valid[1];
    assign bus1.req_sub   = v_sub[1];
    assign bus1.rsp_ready = v_rready[1];
    assign bus1.req_a     = {v_a[1][2], v_a[1][1], v_a[1][0]};
    assign bus1.req_b     = {v_b[1][2], v_b[1][1], v_b[1][0]};
    assign bus1.fpu_out   = fp_addsub(bus1.fpu_a, bus1.fpu_b, bus1.fpu_sub);
    assign bus1.fpu_zflag = (bus1.fpu_out[30:0] == 31'd0);

    fpu_req_arbiter #(.NREQ(2), .FPU_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .o_state(st0), .o_owner(own0)
    );
    fpu_req_arbiter #(.NREQ(3), .FPU_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .o_state(st1), .o_owner(own1)
    );

    assign o_ready[0]  = {1'b0, bus0.req_ready};
    assign o_rvalid[0] = {1'b0, bus0.rsp_valid};
    assign o_rdata[0]  = bus0.rsp_data;
    assign o_rz[0]     = bus0.rsp_zflag;
    assign o_fa[0]     = bus0.fpu_a;
    assign o_fb[0]     = bus0.fpu_b;
    assign o_fs[0]     = bus0.fpu_sub;
    assign o_st[0]     = st0;
    assign o_own[0]    = {1'b0, own0};
    assign o_ready[1]  = bus1.req_ready;
    assign o_rvalid[1] = bus1.rsp_valid;
    assign o_rdata[1]  = bus1.rsp_data;
    assign o_rz[1]     = bus1.rsp_zflag;
    assign o_fa[1]     = bus1.fpu_a;
    assign o_fb[1]     = bus1.fpu_b;
    assign o_fs[1]     = bus1.fpu_sub;
    assign o_st[1]     = st1;
    assign o_own[1]    = own1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name, input int k);
        checks++;
        errors++;
        $display("FAIL %s: instance %0d did not respond within bound (t=%0t)", name, k, $time);
    endtask

    // ---------------- transaction model ----------------
    // phase 0 = idle, 1..lat = operation executing, lat+1 = response pending
    int          m_phase [2];
    int          m_ptr   [2];
    int          m_owner [2];
    logic [31:0] m_a     [2];
    logic [31:0] m_b     [2];
    logic        m_s     [2];
    logic [31:0] m_rd    [2];
    logic        m_z     [2];

    function automatic int model_grant(input int k);
        int i;
        for (int off = 0; off < nreq[k]; off++) begin
            i = (m_ptr[k] + off) % nreq[k];
            if (v_valid[k][i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g;
            logic [31:0] r;
            g = model_grant(k);
            r = fp_addsub(m_a[k], m_b[k], m_s[k]);
            if (rst) begin
                m_phase[k] <= 0;
                m_ptr[k]   <= 0;
                m_owner[k] <= 0;
                m_a[k]     <= '0;
                m_b[k]     <= '0;
                m_s[k]     <= 1'b0;
                m_rd[k]    <= '0;
                m_z[k]     <= 1'b0;
            end else if (m_phase[k] == 0) begin
                if (g >= 0) begin
                    m_a[k]     <= v_a[k][g];
                    m_b[k]     <= v_b[k][g];
                    m_s[k]     <= v_sub[k][g];
                    m_owner[k] <= g;
                    m_ptr[k]   <= (g + 1) % nreq[k];
                    m_phase[k] <= 1;
                end
            end else if (m_phase[k] <= lat[k]) begin
                if (m_phase[k] == lat[k]) begin
                    m_rd[k] <= r;
                    m_z[k]  <= (r[30:0] == 31'd0);
                end
                m_phase[k] <= m_phase[k] + 1;
            end else if (v_rready[k][m_owner[k]]) begin
                m_phase[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int g;
                logic [2:0] e_ready, e_rvalid;
                arb_state_t e_st;
                g = model_grant(k);
                e_ready  = (!rst && m_phase[k] == 0 && g >= 0) ? 3'(1 << g) : 3'b000;
                e_rvalid = (!rst && m_phase[k] == lat[k] + 1) ? 3'(1 << m_owner[k]) : 3'b000;
                e_st     = (m_phase[k] == 0) ? IDLE : (m_phase[k] <= lat[k]) ? EXEC : RESP;
                chk($sformatf("k%0d_req_ready", k), 32'(o_ready[k]), 32'(e_ready));
                chk($sformatf("k%0d_rsp_valid", k), 32'(o_rvalid[k]), 32'(e_rvalid));
                chk($sformatf("k%0d_rsp_data", k), o_rdata[k], m_rd[k]);
                chk($sformatf("k%0d_rsp_zflag", k), 32'(o_rz[k]), 32'(m_z[k]));
                chk($sformatf("k%0d_fpu_a", k), o_fa[k], m_a[k]);
                chk($sformatf("k%0d_fpu_b", k), o_fb[k], m_b[k]);
                chk($sformatf("k%0d_fpu_sub", k), 32'(o_fs[k]), 32'(m_s[k]));
                chk($sformatf("k%0d_state", k), 32'(o_st[k]), 32'(e_st));
                chk($sformatf("k%0d_owner", k), 32'(o_own[k]), 32'(m_owner[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input int k, output int idx, output int n);
        idx = -1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_ready[k] == 3'b000 && n < 100);
        if (o_ready[k] == 3'b000) fail_timeout("req_ready_wait", k);
        else begin
            for (int i = 0; i < 3; i++) if (o_ready[k][i]) idx = i;
        end
    endtask

    task automatic wait_rsp(input int k, output logic [2:0] vec, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_rvalid[k] == 3'b000 && n < 100);
        vec = o_rvalid[k];
        if (vec == 3'b000) fail_timeout("rsp_valid_wait", k);
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    int rr_exp [4] = '{0, 1, 0, 1};

    initial begin
        int idx, n;
        logic [2:0] vec;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            v_valid[k]  = 3'b000;
            v_sub[k]    = 3'b000;
            v_rready[k] = 3'b111;
            for (int i = 0; i < 3; i++) begin
                v_a[k][i] = '0;
                v_b[k][i] = '0;
            end
        end
        next_drive();
        chk_en = 1'b1;
        next_drive();
        rst = 1'b0;

        // single op: 1.0 + 2.0 on requester 0
        v_a[0][0] = 32'h3F800000; v_b[0][0] = 32'h40000000; v_sub[0][0] = 1'b0;
        v_valid[0][0] = 1'b1;
        wait_ready(0, idx, n);
        chk("t1_grant", 32'(idx), 32'd0);
        chk("t1_ready_same_cycle", 32'(n), 32'd1);
        next_drive();
        v_valid[0][0] = 1'b0;
        wait_rsp(0, vec, n);
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_rsp_valid", 32'(vec), 32'h1);
        chk("t1_rsp_data", o_rdata[0], 32'h40400000);
        chk("t1_rsp_zflag", 32'(o_rz[0]), 32'd0);
        chk("t1_fpu_a", o_fa[0], 32'h3F800000);
        chk("t1_fpu_b", o_fb[0], 32'h40000000);
        next_drive();

        // back-pressure on requester 0 while requester 1 waits; non-owner rsp_ready ignored
        v_rready[0] = 3'b000;
        v_valid[0][0] = 1'b1;
        wait_ready(0, idx, n);
        chk("bp_grant", 32'(idx), 32'd0);
        next_drive();
        v_valid[0][0] = 1'b0;
        v_a[0][1] = 32'h40400000; v_b[0][1] = 32'h3F800000; v_sub[0][1] = 1'b1;
        v_valid[0][1] = 1'b1;
        v_rready[0] = 3'b010;
        wait_rsp(0, vec, n);
        chk("bp_latency", 32'(n), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid_held", 32'(o_rvalid[0]), 32'h1);
            chk("bp_rsp_data_held", o_rdata[0], 32'h40400000);
            chk("bp_req_ready_low", 32'(o_ready[0]), 32'h0);
        end
        next_drive();
        v_rready[0] = 3'b011;
        @(negedge clk);
        chk("bp_still_resp", 32'(o_st[0]), 32'(RESP));
        @(negedge clk);
        chk("bp_idle_after", 32'(o_st[0]), 32'(IDLE));
        chk("bp_next_grant_req1", 32'(o_ready[0]), 32'h2);
        next_drive();
        v_valid[0][1] = 1'b0;
        wait_rsp(0, vec, n);
        chk("bp_sub_rsp_valid", 32'(vec), 32'h2);
        chk("bp_sub_rsp_data", o_rdata[0], 32'h40000000);
        next_drive();

        // round robin with both requesters held valid
        v_valid[0] = 3'b011;
        for (int op = 0; op < 4; op++) begin
            wait_ready(0, idx, n);
            chk("rr_grant", 32'(idx), 32'(rr_exp[op]));
            if (op == 3) begin
                next_drive();
                v_valid[0] = 3'b000;
            end
            wait_rsp(0, vec, n);
            chk("rr_rsp_valid", 32'(vec), (rr_exp[op] == 1) ? 32'h2 : 32'h1);
            chk("rr_rsp_data", o_rdata[0], (rr_exp[op] == 1) ? 32'h40000000 : 32'h40400000);
        end
        next_drive();

        // reset while executing aborts the op and clears the pointer
        v_valid[0] = 3'b001;
        wait_ready(0, idx, n);
        chk("rst_pre_grant", 32'(idx), 32'd0);
        next_drive();
        v_valid[0] = 3'b000;
        rst = 1'b1;
        next_drive();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(o_st[0]), 32'(IDLE));
        chk("rst_rsp_data", o_rdata[0], 32'h0);
        chk("rst_fpu_a", o_fa[0], 32'h0);
        chk("rst_fpu_b", o_fb[0], 32'h0);
        chk("rst_fpu_sub", 32'(o_fs[0]), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_no_rsp_valid", 32'(o_rvalid[0]), 32'h0);
        end
        next_drive();
        v_valid[0] = 3'b011;
        wait_ready(0, idx, n);
        chk("rst_next_grant", 32'(idx), 32'd0);
        next_drive();
        v_valid[0] = 3'b000;
        wait_rsp(0, vec, n);
        chk("rst_after_rsp_data", o_rdata[0], 32'h40400000);
        next_drive();

        // FPU_LAT=3: operands held 3 cycles, 10.0 - 10.0 gives a zero result
        v_a[1][0] = 32'h41200000; v_b[1][0] = 32'h41200000; v_sub[1][0] = 1'b1;
        v_valid[1] = 3'b001;
        wait_ready(1, idx, n);
        chk("lat3_grant", 32'(idx), 32'd0);
        next_drive();
        v_valid[1] = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("lat3_exec", 32'(o_st[1]), 32'(EXEC));
            chk("lat3_fpu_a", o_fa[1], 32'h41200000);
            chk("lat3_fpu_sub", 32'(o_fs[1]), 32'd1);
            chk("lat3_no_rsp_yet", 32'(o_rvalid[1]), 32'h0);
        end
        @(negedge clk);
        chk("lat3_rsp_valid", 32'(o_rvalid[1]), 32'h1);
        chk("lat3_rsp_data", o_rdata[1], 32'h0);
        chk("lat3_rsp_zflag", 32'(o_rz[1]), 32'd1);
        next_drive();

        // NREQ=3 wrap: req2 alone, then req0 and req2 together
        v_a[1][2] = 32'h3F800000; v_b[1][2] = 32'h3F800000; v_sub[1][2] = 1'b0;
        v_valid[1] = 3'b100;
        wait_ready(1, idx, n);
        chk("wrap_grant_2", 32'(idx), 32'd2);
        next_drive();
        v_valid[1] = 3'b000;
        wait_rsp(1, vec, n);
        chk("wrap_latency", 32'(n), 32'd4);
        chk("wrap_rsp_valid_2", 32'(vec), 32'h4);
        chk("wrap_rsp_data_2", o_rdata[1], 32'h40000000);
        chk("wrap_rsp_zflag_2", 32'(o_rz[1]), 32'd0);
        next_drive();
        v_valid[1] = 3'b101;
        wait_ready(1, idx, n);
        chk("wrap_grant_0", 32'(idx), 32'd0);
        wait_rsp(1, vec, n);
        chk("wrap_rsp_valid_0", 32'(vec), 32'h1);
        wait_ready(1, idx, n);
        chk("wrap_grant_2b", 32'(idx), 32'd2);
        next_drive();
        v_valid[1] = 3'b000;
        wait_rsp(1, vec, n);
        chk("wrap_rsp_valid_2b", 32'(vec), 32'h4);
        repeat (3) next_drive();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_req_arbiter.md
Name: fpu_req_arbiter

Overview:
- Shares one combinational FP32 adder/subtracter datapath between NREQ requesters.
- Each requester uses a valid/ready request channel (A, B, sub) and a valid/ready response channel (result, zero flag).
- Grants are round-robin. Operands are registered and held on the datapath ports for FPU_LAT cycles, then the result is captured and returned to the owning requester.
- Sits between client engines and the adder/subtracter wrapper; the datapath itself stays outside this block.

Parameters:
- NREQ, 2, number of requesters (2..8).
- FPU_LAT, 1, cycles operands are held before the result is sampled (1..15).
- IDW, $clog2(NREQ), width of the owner index.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request accepted this cycle
- req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
- req_b  in  NREQ*32  operand B, same packing as req_a
- req_sub  in  NREQ  1 = A-B, 0 = A+B
- rsp_valid  out  NREQ  result valid, owner bit only
- rsp_ready  in  NREQ  requester accepts result
- rsp_data  out  32  FP32 result, shared by all requesters
- rsp_zflag  out  1  zero flag captured with the result
- fpu_a  out  32  to datapath A
- fpu_b  out  32  to datapath B
- fpu_sub  out  1  to datapath sub
- fpu_out  in  32  datapath result
- fpu_zflag  in  1  datapath zero flag

Behaviour:
- Reset: one clock; synchronous, active-high reset (rst). On reset:
  - state=IDLE, rr_ptr=0, owner=0, lat_cnt=0.
  - Operand registers, rsp_data and rsp_zflag = 0.
  - req_ready=0, rsp_valid=0.
  - fpu_a=0, fpu_b=0, fpu_sub=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[grant]=1 is combinational; all other req_ready bits are 0. If no request is valid, req_ready=0.
  - On handshake: latch req_a/req_b/req_sub of the grant into the operand registers, owner=grant, rr_ptr=(grant+1) mod NREQ, lat_cnt=FPU_LAT-1, go to EXEC.
- EXEC:
  - fpu_a/fpu_b/fpu_sub are driven from the operand registers (registered, stable for the whole op).
  - If lat_cnt!=0, decrement it.
  - If lat_cnt==0, capture fpu_out into rsp_data and fpu_zflag into rsp_zflag, go to RESP.
  - EXEC lasts exactly FPU_LAT cycles.
- RESP:
  - rsp_valid[owner]=1; all other rsp_valid bits are 0.
  - rsp_ready[owner]=1 → go to IDLE next cycle. rsp_ready on any non-owner bit is ignored.
  - Results are held indefinitely under back-pressure.
- Throughput and latency:
  - req_ready=0 in EXEC and RESP, so there is one operation in flight at a time.
  - Minimum issue-to-issue spacing is FPU_LAT+2 cycles.
  - Request handshake to rsp_valid = FPU_LAT+1 cycles.
- Fixed behaviours at boundaries:
  - Operand registers and fpu_* keep their last values outside EXEC, so the datapath does not toggle.
  - A requester dropping req_valid before its handshake: no effect; the grant is recomputed every IDLE cycle.
  - rr_ptr advances only on a handshake, never on an idle cycle.
  - Wrap-around: grant at NREQ-1 → rr_ptr=0.
  - A requester may hold req_valid while its own response is pending; it is re-arbitrated only after RESP completes.
  - rst in EXEC or RESP aborts the operation; the result is discarded and there is no rsp_valid afterwards.
  - Arithmetic is pass-through: no width changes, no rounding, no NaN handling in this block.

Decomposition:
- Package fpu_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t.
  - typedef struct packed {logic [31:0] a; logic [31:0] b; logic sub;} fpu_op_t.
  - localparam FP_W=32.
- One sub-module, rr_grant: combinational round-robin priority select.
  - Inputs: req[NREQ], ptr[IDW].
  - Outputs: gnt_idx[IDW], gnt_any.
  - Reusable by other shared-resource arbiters in the design.

Test Plan:
- Single op, NREQ=2, FPU_LAT=1, model datapath attached. req0: A=0x3F800000, B=0x40000000, sub=0. Required: req_ready[0] in the same cycle; fpu_a/fpu_b valid 1 cycle later; rsp_valid[0] 2 cycles after handshake with rsp_data=0x40400000, rsp_zflag=0.
- Round-robin with req0 and req1 both held valid. Required: grants alternate 0,1,0,1 over 4 ops. Subtraction req1: A=0x40400000, B=0x3F800000, sub=1 → rsp_data=0x40000000 on rsp_valid[1] only.
- Back-pressure: hold rsp_ready[0]=0 for 5 cycles. Required: rsp_valid[0] and rsp_data stable; req_ready=0 throughout; IDLE is entered the cycle after rsp_ready[0]=1.
- FPU_LAT=3. Required: fpu_a/fpu_b/fpu_sub stable for exactly 3 cycles; capture on the 3rd; handshake to rsp_valid = 4 cycles. Zero result: A=0x41200000 minus B=0x41200000 → rsp_zflag=1.
- Reset in EXEC: assert rst for 1 cycle mid-op. Required: next cycle all outputs 0; no rsp_valid for the aborted op; the next grant is requester 0.
- NREQ=3, valid on req2 only, then on 0 and 2 together. Required: grant 2, then rr_ptr=0 → grant 0, then 2. The wrap from 2 to 0 is verified.
